// File: rtl/pc_redirect_unit_if.sv
// pc_redirect_unit_if: fetch-PC bus; master drives branch/stall inputs, slave (the PC unit) drives pc, flush and stats
interface pc_redirect_unit_if #(parameter int XLEN = 32);
  logic            br_taken;
  logic [XLEN-1:0] br_target;
  logic            fetch_stall;
  logic            pipe_stall;
  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic            flush;
  logic            redirect;
  logic            misalign;
  logic [31:0]     taken_cnt;
  logic [31:0]     ignored_cnt;
  modport master (
    output br_taken, br_target, fetch_stall, pipe_stall,
    input  pc, pc_valid, flush, redirect, misalign, taken_cnt, ignored_cnt
  );
  modport slave (
    input  br_taken, br_target, fetch_stall, pipe_stall,
    output pc, pc_valid, flush, redirect, misalign, taken_cnt, ignored_cnt
  );
endinterface

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: owns the fetch PC, applies (or defers under fetch_stall) branch redirects and drives the IF/ID flush window; ports clk, reset, bus (slave); BR_STATS_EN enables taken_cnt/ignored_cnt
module pc_redirect_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter int              PC_INC       = 4,
  parameter int              FLUSH_CYCLES = 2
) (
  input logic               clk,
  input logic               reset,
  pc_redirect_unit_if.slave bus
);
  typedef enum logic [1:0] {RUN, PEND, FLUSH} state_t;
  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] pc_q, pc_d, pend_q, pend_d, tgt;
  logic            pc_valid_q, redirect_q, redirect_d, misalign_q, misalign_d;
  logic            act_run, apply, capture, hold;
  // the last flush cycle already behaves like RUN, so a branch sampled on the closing edge is taken
  assign act_run = state_q == RUN || (state_q == FLUSH && cnt_q == 3'd1);
  assign apply   = (act_run && bus.br_taken && !bus.fetch_stall) || (state_q == PEND && !bus.fetch_stall);
  assign capture = act_run && bus.br_taken && bus.fetch_stall;
  assign tgt     = state_q == PEND ? pend_q : bus.br_target;
  // the first cycle after reset issues RESET_PC itself, so the PC only advances once pc_valid is up
  assign hold    = bus.fetch_stall || bus.pipe_stall || state_q == PEND || !pc_valid_q;
  always_comb begin
    pc_d       = apply ? {tgt[XLEN-1:2], 2'b00} : hold ? pc_q : pc_q + XLEN'(PC_INC);
    state_d    = apply ? FLUSH : capture ? PEND : act_run ? RUN : state_q;
    cnt_d      = apply ? 3'(FLUSH_CYCLES) : cnt_q != 3'd0 ? cnt_q - 3'd1 : 3'd0;
    pend_d     = capture ? bus.br_target : pend_q;
    redirect_d = apply;
    misalign_d = apply && tgt[1:0] != 2'b00;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      pc_q       <= RESET_PC;
      pend_q     <= '0;
      pc_valid_q <= 1'b0;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pc_valid_q <= 1'b1;
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
    end
  end
  assign bus.pc       = pc_q;
  assign bus.pc_valid = pc_valid_q;
  assign bus.flush    = state_q != RUN;
  assign bus.redirect = redirect_q;
  assign bus.misalign = misalign_q;
`ifdef BR_STATS_EN
  logic        ignore;
  logic [31:0] taken_q, taken_d, ignored_q, ignored_d;
  // a branch arriving while a redirect is pending or the flush window is open is wrong-path
  assign ignore = bus.br_taken && !act_run;
  always_comb begin
    taken_d   = apply && taken_q != '1 ? taken_q + 32'd1 : taken_q;
    ignored_d = ignore && ignored_q != '1 ? ignored_q + 32'd1 : ignored_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      taken_q   <= '0;
      ignored_q <= '0;
    end else begin
      taken_q   <= taken_d;
      ignored_q <= ignored_d;
    end
  end
  assign bus.taken_cnt   = taken_q;
  assign bus.ignored_cnt = ignored_q;
`else
  assign bus.taken_cnt   = '0;
  assign bus.ignored_cnt = '0;
`endif
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed plus random stimulus checked against a cycle-level reference model of the fetch PC
module tb_pc_redirect_unit;
  localparam int F = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  pc_redirect_unit_if #(.XLEN(32)) bus ();
  pc_redirect_unit #(.XLEN(32), .RESET_PC(32'h0), .PC_INC(4), .FLUSH_CYCLES(F)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] m_pc, m_tgt;
  bit m_valid, m_redir, m_mis, m_pend;
  int m_left;
  longint m_taken, m_ign;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic take(input logic [31:0] t);
    m_pc    = {t[31:2], 2'b00};
    m_redir = 1;
    m_mis   = t[1:0] != 2'b00;
    m_left  = F;
    m_pend  = 0;
    m_taken++;
  endtask
  task automatic model();
    if (reset) begin
      m_pc = 0; m_valid = 0; m_redir = 0; m_mis = 0; m_pend = 0; m_left = 0; m_taken = 0; m_ign = 0;
    end else begin
      m_redir = 0;
      m_mis   = 0;
      if (m_pend) begin
        if (bus.br_taken) m_ign++;
        if (!bus.fetch_stall) take(m_tgt);
      end else if (bus.br_taken && m_left <= 1) begin
        if (bus.fetch_stall) begin
          m_pend = 1; m_tgt = bus.br_target; m_left = 0;
        end else take(bus.br_target);
      end else begin
        if (bus.br_taken) m_ign++;
        if (m_valid && !bus.fetch_stall && !bus.pipe_stall) m_pc = m_pc + 32'd4;
        if (m_left > 0) m_left--;
      end
      m_valid = 1;
    end
  endtask
  task automatic check_all();
    check("pc", bus.pc, m_pc);
    check("pc_valid", 32'(bus.pc_valid), 32'(m_valid));
    check("flush", 32'(bus.flush), 32'(m_pend || m_left > 0));
    check("redirect", 32'(bus.redirect), 32'(m_redir));
    check("misalign", 32'(bus.misalign), 32'(m_mis));
`ifdef BR_STATS_EN
    check("taken_cnt", bus.taken_cnt, 32'(m_taken));
    check("ignored_cnt", bus.ignored_cnt, 32'(m_ign));
`else
    check("taken_cnt", bus.taken_cnt, 32'h0);
    check("ignored_cnt", bus.ignored_cnt, 32'h0);
`endif
  endtask
  task automatic step(input logic r, input logic b, input logic [31:0] t, input logic fs, input logic ps);
    reset = r;
    bus.br_taken = b;
    bus.br_target = t;
    bus.fetch_stall = fs;
    bus.pipe_stall = ps;
    @(posedge clk);
    model();
    @(negedge clk);
    check_all();
  endtask
  initial begin
    bus.br_taken = 0; bus.br_target = 0; bus.fetch_stall = 0; bus.pipe_stall = 0;
    repeat (3) step(1, 0, 0, 0, 0);
    check("rst_pc", bus.pc, 32'h0);
    check("rst_valid", 32'(bus.pc_valid), 32'h0);
    step(0, 0, 0, 0, 0);
    check("first_valid", 32'(bus.pc_valid), 32'h1);
    check("first_pc", bus.pc, 32'h0);
    step(0, 0, 0, 0, 0);
    check("seq_pc4", bus.pc, 32'h4);
    step(0, 0, 0, 0, 0);
    check("seq_pc8", bus.pc, 32'h8);
    step(0, 1, 32'h100, 0, 0);
    check("br_pc", bus.pc, 32'h100);
    check("br_redirect", 32'(bus.redirect), 32'h1);
    check("br_flush1", 32'(bus.flush), 32'h1);
    step(0, 0, 0, 0, 0);
    check("br_pc104", bus.pc, 32'h104);
    check("br_flush2", 32'(bus.flush), 32'h1);
    step(0, 0, 0, 0, 0);
    check("br_pc108", bus.pc, 32'h108);
    check("br_flush_end", 32'(bus.flush), 32'h0);
    step(0, 1, 32'h200, 1, 0);
    check("pend_hold", bus.pc, 32'h108);
    check("pend_flush", 32'(bus.flush), 32'h1);
    step(0, 1, 32'h300, 1, 0);
    step(0, 0, 0, 1, 0);
    check("pend_flush3", 32'(bus.flush), 32'h1);
    step(0, 0, 0, 0, 0);
    check("pend_pc", bus.pc, 32'h200);
    check("pend_redirect", 32'(bus.redirect), 32'h1);
    step(0, 1, 32'h400, 0, 0);
    check("wrongpath_pc", bus.pc, 32'h204);
`ifdef BR_STATS_EN
    check("wrongpath_ign", bus.ignored_cnt, 32'h2);
`endif
    step(0, 0, 0, 0, 0);
    step(0, 1, 32'h203, 0, 0);
    check("mis_pc", bus.pc, 32'h200);
    check("mis_pulse", 32'(bus.misalign), 32'h1);
    step(0, 0, 0, 0, 0);
    check("mis_drop", 32'(bus.misalign), 32'h0);
    step(0, 1, 32'hFFFF_FFFC, 0, 0);
    step(0, 0, 0, 0, 0);
    check("wrap_pc", bus.pc, 32'h0);
    step(0, 1, 32'h500, 0, 0);
    step(1, 0, 0, 0, 1);
    check("midrst_pc", bus.pc, 32'h0);
    check("midrst_flush", 32'(bus.flush), 32'h0);
    check("midrst_taken", bus.taken_cnt, 32'h0);
    for (int i = 0; i < 600; i++)
      step($urandom_range(63) == 0, $urandom_range(3) == 0, $urandom, $urandom_range(3) == 0, $urandom_range(3) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Fetch-side stage directly downstream of the branch-condition unit.
- Consumes the registered br_taken, plus a branch/jump target registered in the same cycle, and owns the architectural fetch PC.
- Selects the next PC: sequential or redirect. Holds the PC while the instruction cache or pipeline stalls.
- Produces the flush window that kills wrong-path instructions in IF/ID.
- Defers a redirect that arrives while the instruction cache is stalled.

Parameters:
XLEN, 32, PC/target width
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_INC, 4, sequential increment
FLUSH_CYCLES, 2, cycles flush stays high after a redirect is applied (legal range 1..7)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
br_taken  input  1  registered branch/jump decision from the branch-condition stage
br_target  input  XLEN  redirect target, valid when br_taken=1
fetch_stall  input  1  instruction cache not ready; PC must hold
pipe_stall  input  1  hazard stall from decode; PC must hold
pc  output  XLEN  current fetch address
pc_valid  output  1  pc is a live fetch request
flush  output  1  kill IF/ID contents this cycle
redirect  output  1  one-cycle pulse in the cycle pc takes a redirect target
misalign  output  1  one-cycle pulse: applied target had bits [1:0] != 0
taken_cnt  output  32  number of redirects applied
ignored_cnt  output  32  number of br_taken pulses dropped inside the flush window

Behaviour:
- Reset (synchronous, checked at posedge clk):
  - pc=RESET_PC; pc_valid=0; flush=0; redirect=0; misalign=0; taken_cnt=0; ignored_cnt=0.
  - State RUN; pending target cleared.
  - pc_valid goes to 1 on the first edge with reset=0.
- Reset asserted in any state, including PEND/FLUSH, aborts the operation: pending target discarded, flush counter zeroed, all outputs return to reset values.
- States: RUN, PEND, FLUSH.
- RUN:
  - br_taken=1 and fetch_stall=0:
    - next pc={br_target[XLEN-1:2],2'b00}.
    - redirect=1 next cycle; misalign=1 next cycle if br_target[1:0]!=0.
    - flush counter loaded with FLUSH_CYCLES; go to FLUSH.
    - pipe_stall is ignored: redirect has priority.
  - br_taken=1 and fetch_stall=1:
    - capture br_target into the pending register; pc holds; go to PEND.
  - br_taken=0 and (fetch_stall or pipe_stall): pc holds.
  - Otherwise pc <= pc+PC_INC, modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0.
- PEND:
  - flush=1 every cycle; pc holds.
  - Further br_taken pulses are counted in ignored_cnt and do not overwrite the pending target.
  - When fetch_stall=0: pc <= aligned pending target; redirect and misalign behave as in RUN; counter loaded with FLUSH_CYCLES; go to FLUSH.
- FLUSH:
  - flush=1 while counter!=0; counter decrements every cycle regardless of stalls.
  - pc advances from the target under the RUN sequential/hold rules.
  - br_taken=1 here comes from a wrong-path instruction: ignored, ignored_cnt++.
  - When counter reaches 0: flush=0; go to RUN. A br_taken on that same edge is handled as in RUN.
- Latency:
  - br_taken sampled at edge N → pc=target and redirect=1 after edge N, i.e. visible in cycle N+1.
  - flush is high in cycles N+1..N+FLUSH_CYCLES.
- Arithmetic: all PC math is unsigned XLEN-bit; the carry is discarded.
- Counters saturate at 32'hFFFF_FFFF.

Optional Feature:
- Macro BR_STATS_EN.
- Defined: taken_cnt and ignored_cnt are implemented as specified.
- Undefined: both counters are removed; taken_cnt and ignored_cnt are driven constant 0.
- Every other behaviour is identical in both cases.

Test Plan:
- Reset held 3 cycles, then released; no stalls → pc_valid=1 first cycle after release; pc sequence 0,4,8,12.
- br_taken=1, br_target=32'h100 at pc=8, no stalls → next cycle pc=32'h100, redirect=1; flush=1 for exactly 2 cycles; then pc=32'h104, 32'h108; taken_cnt=1.
- br_taken=1, br_target=32'h200 while fetch_stall=1 for 3 cycles:
  - pc holds; flush=1 throughout.
  - Cycle after fetch_stall drops: pc=32'h200, redirect=1.
  - A second br_taken during the stall → ignored_cnt=1; target stays 32'h200.
- br_taken=1 again in the cycle after a redirect (inside the flush window) → pc unaffected; ignored_cnt increments.
- pc=32'hFFFF_FFFC, no stalls → next pc=0.
- br_target=32'h203 → pc=32'h200; misalign pulses 1 cycle.
- Reset asserted mid-FLUSH with pipe_stall=1 → next cycle pc=RESET_PC, flush=0, counters 0.
